alu_console: RTL

Parametrised sequential front-end for the ALU on the Basys3 board. It debounces the board buttons and captures operand A, operand B and the op code from the switches in successive steps. It issues a single-cycle enable to the ALU, waits a configurable latency, then latches the result and flags for paged display on the LEDs. A chain mode feeds the previous result back as operand A, so multi-step calculations need no re-entry.

---
 rtl/alu_console_pkg.sv | 28 ++
 rtl/alu_console_debounce.sv | 49 ++++
 rtl/alu_console.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_console_pkg.sv
// Shared types and constants for the ALU console front-end.
// State encoding, step indicator patterns and page-count helper.
package alu_console_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_A,
    ST_LOAD_B,
    ST_LOAD_OP,
    ST_EXEC,
    ST_WAIT,
    ST_SHOW
  } state_e;

  localparam logic [2:0] STEP_A    = 3'b001;
  localparam logic [2:0] STEP_B    = 3'b010;
  localparam logic [2:0] STEP_OP   = 3'b100;
  localparam logic [2:0] STEP_NONE = 3'b000;

  function automatic int unsigned ceil_div(
    input int unsigned num,
    input int unsigned den
  );
    return (num + den - 1) / den;
  endfunction

  localparam int unsigned PAGES_DEFAULT = ceil_div(16, 8);

endpackage

// File: rtl/alu_console_debounce.sv
// Button conditioner: 2-flop synchronizer plus stable-level counter.
// Emits a one-cycle pulse on each debounced rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;

  // A level change is accepted only after DEBOUNCE_CYCLES equal samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == LAST) begin
          level_q <= sync2_q;
          pulse_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/alu_console.sv
// Sequential switch/button front-end for a board-level ALU.
// Captures A, B, op in steps, issues, waits, and pages the result.
module alu_console
  import alu_console_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned LED_WIDTH       = 8,
  parameter int unsigned OP_WIDTH        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned ALU_LATENCY     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     sw,
  input  logic                 btn_enter,
  input  logic                 btn_chain,
  input  logic                 btn_page,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [OP_WIDTH-1:0]  alu_op,
  output logic                 alu_enable,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_carry,
  input  logic                 alu_overflow,
  output logic [LED_WIDTH-1:0] led,
  output logic                 flag_zero_led,
  output logic                 flag_carry_led,
  output logic                 flag_overflow_led,
  output logic [2:0]           step_led,
  output logic                 busy
);

  localparam int unsigned PAGES = ceil_div(WIDTH, LED_WIDTH);
  localparam int unsigned PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned EXT   = PAGES * LED_WIDTH;
  localparam int unsigned LW    =
    (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(ALU_LATENCY - 1);

  logic enter_p;
  logic chain_p;
  logic page_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_enter),
    .pulse (enter_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chain (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_chain),
    .pulse (chain_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_page (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_page),
    .pulse (page_p)
  );

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [OP_WIDTH-1:0]  op_q;
  logic [WIDTH-1:0]     res_q;
  logic                 zero_q;
  logic                 carry_q;
  logic                 ovf_q;
  logic [PW-1:0]        page_q;
  logic [LW-1:0]        wcnt_q;
  logic                 en_q;
  logic                 busy_q;
  logic [2:0]           step_q;
  logic [LED_WIDTH-1:0] led_q;

  logic                 loading;
  logic [EXT-1:0]       src;
  logic [LED_WIDTH-1:0] led_d;

  // Zero-extend so a partial last page reads zeros above WIDTH.
  always_comb begin
    loading = (state_q == ST_LOAD_A) ||
              (state_q == ST_LOAD_B) ||
              (state_q == ST_LOAD_OP);
    src     = loading ? EXT'(sw) : EXT'(res_q);
    led_d   = src[page_q*LED_WIDTH +: LED_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      page_q  <= '0;
      wcnt_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= STEP_A;
      led_q   <= '0;
    end else begin
      led_q <= led_d;
      en_q  <= 1'b0;
      if (page_p) begin
        page_q <= (page_q == PAGE_LAST) ? '0 : page_q + PW'(1);
      end
      unique case (state_q)
        ST_LOAD_A: begin
          if (enter_p) begin
            a_q     <= sw;
            state_q <= ST_LOAD_B;
            step_q  <= STEP_B;
          end
        end
        ST_LOAD_B: begin
          if (enter_p) begin
            b_q     <= sw;
            state_q <= ST_LOAD_OP;
            step_q  <= STEP_OP;
          end
        end
        ST_LOAD_OP: begin
          if (enter_p) begin
            op_q    <= sw[OP_WIDTH-1:0];
            state_q <= ST_EXEC;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            step_q  <= STEP_NONE;
          end
        end
        ST_EXEC: begin
          state_q <= ST_WAIT;
          wcnt_q  <= '0;
        end
        ST_WAIT: begin
          if (wcnt_q == LAT_LAST) begin
            res_q   <= alu_result;
            zero_q  <= alu_zero;
            carry_q <= alu_carry;
            ovf_q   <= alu_overflow;
            state_q <= ST_SHOW;
            busy_q  <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q + LW'(1);
          end
        end
        ST_SHOW: begin
          if (enter_p) begin
            state_q <= ST_LOAD_A;
            step_q  <= STEP_A;
          end else if (chain_p) begin
            a_q     <= res_q;
            state_q <= ST_LOAD_B;
            step_q  <= STEP_B;
          end
        end
        default: begin
          state_q <= ST_LOAD_A;
          step_q  <= STEP_A;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a             = a_q;
  assign alu_b             = b_q;
  assign alu_op            = op_q;
  assign alu_enable        = en_q;
  assign led               = led_q;
  assign flag_zero_led     = zero_q;
  assign flag_carry_led    = carry_q;
  assign flag_overflow_led = ovf_q;
  assign step_led          = step_q;
  assign busy              = busy_q;

endmodule
